// File: rtl/psram_uart_pkg.sv
// Shared constants and state encoding for the UART-to-PSRAM command bridge.
package psram_uart_pkg;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h4B;
  localparam logic [7:0] RSP_BAD  = 8'h3F;
  localparam logic [7:0] RSP_ERR  = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_DATA, ST_MREQ, ST_MBUSY, ST_SEND
  } state_t;
endpackage

// File: rtl/psram_uart_bridge.sv
// Decodes 'R'/'W' byte frames from the UART into PSRAM user-port accesses
// and returns read data, an acknowledge or an error byte to the transmitter.
module psram_uart_bridge
  import psram_uart_pkg::*;
#(
  parameter logic [15:0] BYTE_TIMEOUT = 16'd8400,
  parameter logic [7:0]  MEM_TIMEOUT  = 8'd64
) (
  input  logic        mem_clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        psram_ready,
  input  logic        endcommand,
  input  logic [15:0] mem_rdata,
  output logic        read_sw,
  output logic        write_sw,
  output logic [23:0] address,
  output logic [15:0] data_in,
  output logic        busy,
  output logic        err
);

  state_t      state;
  logic        is_read;
  logic        two_bytes;
  logic [1:0]  byte_cnt;
  logic [15:0] byte_tmr;
  logic [7:0]  mem_tmr;
  logic [7:0]  resp_lo;

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      is_read   <= 1'b0;
      two_bytes <= 1'b0;
      byte_cnt  <= '0;
      byte_tmr  <= '0;
      mem_tmr   <= '0;
      resp_lo   <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      read_sw   <= 1'b0;
      write_sw  <= 1'b0;
      address   <= '0;
      data_in   <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_valid && psram_ready) begin
            byte_cnt <= '0;
            byte_tmr <= '0;
            busy     <= 1'b1;
            if (rx_data == OP_WRITE || rx_data == OP_READ) begin
              is_read <= (rx_data == OP_READ);
              state   <= ST_ADDR;
            end else begin
              tx_data   <= RSP_BAD;
              tx_valid  <= 1'b1;
              two_bytes <= 1'b0;
              state     <= ST_SEND;
            end
          end
        end
        ST_ADDR, ST_DATA: begin
          if (rx_valid) begin
            byte_tmr <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            mem_tmr  <= '0;
            if (state == ST_ADDR) begin
              address <= {address[15:0], rx_data};
              if (byte_cnt == 2'd2) begin
                byte_cnt <= '0;
                if (is_read) begin
                  read_sw <= 1'b1;
                  state   <= ST_MREQ;
                end else begin
                  state <= ST_DATA;
                end
              end
            end else begin
              data_in <= {data_in[7:0], rx_data};
              if (byte_cnt == 2'd1) begin
                write_sw <= 1'b1;
                state    <= ST_MREQ;
              end
            end
          end else if (byte_tmr == BYTE_TIMEOUT - 16'd1) begin
            // Stalled frame: discard silently and flag it.
            state <= ST_IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            byte_tmr <= byte_tmr + 16'd1;
          end
        end
        ST_MREQ, ST_MBUSY: begin
          if ((state == ST_MREQ && !endcommand) || (state == ST_MBUSY && endcommand)) begin
            mem_tmr <= '0;
            if (state == ST_MREQ) begin
              state <= ST_MBUSY;
            end else begin
              read_sw   <= 1'b0;
              write_sw  <= 1'b0;
              tx_valid  <= 1'b1;
              two_bytes <= is_read;
              tx_data   <= is_read ? mem_rdata[15:8] : RSP_ACK;
              resp_lo   <= mem_rdata[7:0];
              state     <= ST_SEND;
            end
          end else if (mem_tmr == MEM_TIMEOUT - 8'd1) begin
            read_sw   <= 1'b0;
            write_sw  <= 1'b0;
            tx_data   <= RSP_ERR;
            tx_valid  <= 1'b1;
            two_bytes <= 1'b0;
            err       <= 1'b1;
            state     <= ST_SEND;
          end else begin
            mem_tmr <= mem_tmr + 8'd1;
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            if (two_bytes) begin
              tx_data   <= resp_lo;
              two_bytes <= 1'b0;
            end else begin
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              state    <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
      // Bytes arriving while an access or response is in flight are lost.
      if (rx_valid && (state == ST_MREQ || state == ST_MBUSY || state == ST_SEND))
        err <= 1'b1;
    end
  end

endmodule
